inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port fetch_en, input, 1; 1 = issue fetches, 0 = idle.
REQ-005 SHALL have port imem_addr, output, 32, byte address driven to the instruction memory.
REQ-006 SHALL have port imem_rdata, input, 32; little-endian word returned one cycle after imem_addr is sampled.
REQ-007 SHALL have port inst, output, 32, the fetched instruction; equals imem_rdata.
REQ-008 SHALL have port inst_pc, output, 32, the byte address of inst.
REQ-009 SHALL have port inst_valid, output, 1, meaning inst and inst_pc are valid this cycle.
REQ-010 SHALL have port inst_ready, input, 1; the consumer accepts the instruction when inst_valid and inst_ready are both 1.
REQ-011 SHALL have port redirect_valid, input, 1, a branch or jump redirect request.
REQ-012 SHALL have port redirect_pc, input, 32, the redirect target address.
REQ-013 SHALL have port fetch_fault, output, 1, sticky misaligned-redirect flag (see Configuration).

Function
REQ-014 SHALL hold state pend (1 bit) and pend_pc (32 bits); pend=1 means a read of pend_pc was issued in the previous cycle.
REQ-015 SHALL drive imem_addr combinationally, first match wins:
- redirect_valid -> redirect_pc
- pend and not inst_ready -> pend_pc (re-read during a stall)
- pend -> pend_pc+4
- otherwise -> the stored restart address, which is RESET_PC after reset.
REQ-016 SHALL at each clock edge load pend_pc <= imem_addr and pend <= fetch_en & ~fetch_fault.
REQ-017 SHALL drive inst_valid = pend & ~redirect_valid, with inst_pc = pend_pc, giving a fetch-to-valid latency of exactly 1 cycle.
REQ-018 SHALL, while stalled (inst_valid=1, inst_ready=0), hold inst_pc and re-present the same address so inst stays constant.
REQ-019 SHALL discard the word presented in a redirect cycle (inst_valid=0) even if inst_ready=1; inst_valid returns 1 one cycle later with inst_pc=redirect_pc.
REQ-020 SHALL, when fetch_en=0 and a read is pending, let that final word complete, then deassert pend.
REQ-021 SHALL store the restart address (pend_pc+4 if the last word was accepted, else pend_pc) so that re-asserting fetch_en loses and duplicates no instruction.
REQ-022 SHALL wrap pend_pc+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 SHALL let a redirect coincident with fetch_en=0 update the restart address to redirect_pc.

Reset
REQ-024 SHALL, on rst_n low, immediately and asynchronously clear pend and fetch_fault and set pend_pc and the restart address to RESET_PC.
REQ-025 SHALL, while rst_n is low, hold inst_valid=0 and imem_addr=RESET_PC.
REQ-026 SHALL, when reset is asserted mid-stall or mid-redirect, drop the pending word with no partial output.

Configuration
REQ-027 SHALL, when macro FETCH_ALIGN_CHECK_EN is defined, treat redirect_valid with redirect_pc[1:0]!=0 as a fault:
- fetch_fault is set and stays set until reset
- pend is forced to 0, so inst_valid stays 0
- imem_addr holds the faulting address.
REQ-028 SHALL, when FETCH_ALIGN_CHECK_EN is undefined, force redirect_pc[1:0] to 2'b00 and tie fetch_fault to 0.

Verification
REQ-029 Reset release, fetch_en=1, inst_ready=1, RESET_PC=0 -> imem_addr sequence 0,4,8,...; inst_valid=1 from the 2nd cycle, inst_pc trailing by 1 cycle.
REQ-030 inst_ready=0 for 3 cycles at inst_pc=0x8 -> inst_pc=0x8 and inst constant for all 3; 0xC follows the cycle after acceptance; no skipped or duplicated PC.
REQ-031 redirect_valid=1, redirect_pc=0x100 while inst_pc=0x10 is presented -> inst_valid=0 that cycle; next cycle inst_pc=0x100; then 0x104.
REQ-032 fetch_en dropped after acceptance of 0x20, raised 5 cycles later -> next inst_pc=0x24, no valid output in between.
REQ-033 With FETCH_ALIGN_CHECK_EN, redirect_pc=0x102 -> fetch_fault=1 next cycle, inst_valid stays 0 until rst_n pulse; without the macro -> fetch resumes at 0x100.
REQ-034 pend_pc=0xFFFF_FFFC accepted -> next inst_pc=0x0000_0000; rst_n pulsed low mid-stall -> inst_valid=0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// Sequential instruction fetch unit with stall re-read, redirect and restart tracking.
// Optional misaligned-redirect fault detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    logic        pend_q;
    logic        pend_d;
    logic [31:0] pend_pc_q;
    logic [31:0] pend_pc_d;
    logic [31:0] redir_pc;
    logic        fault_q;
    logic        fault_d;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign;

    assign redir_pc = redirect_pc;
    assign misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign fault_d  = fault_q | misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    logic unused_redir_lsbs;

    assign redir_pc          = {redirect_pc[31:2], 2'b00};
    assign fault_q           = 1'b0;
    assign fault_d           = 1'b0;
    assign unused_redir_lsbs = ^redirect_pc[1:0];
`endif

    // pend_pc also serves as the restart address while idle: it always holds
    // the last issued address, which is the next instruction not yet accepted.
    always_comb begin
        imem_addr = pend_pc_q;
        if (!rst_n) begin
            imem_addr = RESET_PC;
        end else if (redirect_valid) begin
            imem_addr = redir_pc;
        end else if (pend_q && !inst_ready) begin
            imem_addr = pend_pc_q;
        end else if (pend_q) begin
            imem_addr = pend_pc_q + 32'd4;
        end
    end

    assign pend_pc_d = imem_addr;
    assign pend_d    = fetch_en & ~fault_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            pend_pc_q <= RESET_PC;
        end else begin
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign inst_valid  = pend_q & ~redirect_valid;
    assign inst_pc     = pend_pc_q;
    assign inst        = imem_rdata;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a registered memory model returns a word derived
// from its address, so every valid inst can be checked against its inst_pc.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int n_vec;
  int n_bad;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F00;
  endfunction

  // memory returns the word one cycle after the address is sampled
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // drive inputs just after a rising edge, check at the falling edge
  task automatic cycle(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic vld, input logic [31:0] pc, input logic [31:0] addr);
    fetch_en       = fe;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, vld});
    chk("imem_addr", imem_addr, addr);
    if (vld) begin
      chk("inst_pc", inst_pc, pc);
      chk("inst", inst, mem_word(pc));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic fe, input logic rdy, input logic vld,
                     input logic [31:0] pc, input logic [31:0] addr);
    cycle(fe, rdy, 1'b0, 32'h0, vld, pc, addr);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // sequential fetch from RESET_PC
    run(1, 1, 0, 32'h0, 32'h0);
    run(1, 1, 1, 32'h0, 32'h4);
    run(1, 1, 1, 32'h4, 32'h8);
    // three-cycle stall at 0x8
    run(1, 0, 1, 32'h8, 32'h8);
    run(1, 0, 1, 32'h8, 32'h8);
    run(1, 0, 1, 32'h8, 32'h8);
    run(1, 1, 1, 32'h8, 32'hC);
    run(1, 1, 1, 32'hC, 32'h10);
    // redirect while 0x10 is presented
    cycle(1, 1, 1, 32'h100, 0, 32'h10, 32'h100);
    run(1, 1, 1, 32'h100, 32'h104);
    run(1, 1, 1, 32'h104, 32'h108);
    // reach 0x20, drop fetch_en as it is accepted, idle 5 cycles
    cycle(1, 1, 1, 32'h20, 0, 32'h0, 32'h20);
    run(0, 1, 1, 32'h20, 32'h24);
    for (int i = 0; i < 5; i++) run(0, 1, 0, 32'h0, 32'h24);
    run(1, 1, 0, 32'h0, 32'h24);
    run(1, 1, 1, 32'h24, 32'h28);
    // wrap past the top of the address space
    cycle(1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0, 32'hFFFF_FFF8);
    run(1, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    run(1, 1, 1, 32'hFFFF_FFFC, 32'h0);
    run(1, 1, 1, 32'h0, 32'h4);
    run(1, 0, 1, 32'h4, 32'h4);
    // asynchronous reset in the middle of a stall
    inst_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midstall_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("midstall_rst_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(1, 1, 0, 32'h0, 32'h0);
    run(1, 1, 1, 32'h0, 32'h4);
    // redirect while fetch_en is low updates the restart address
    cycle(0, 1, 1, 32'h200, 0, 32'h0, 32'h200);
    run(0, 1, 0, 32'h0, 32'h200);
    run(1, 1, 0, 32'h0, 32'h200);
    run(1, 1, 1, 32'h200, 32'h204);
    // misaligned redirect
`ifdef FETCH_ALIGN_CHECK_EN
    cycle(1, 1, 1, 32'h102, 0, 32'h0, 32'h102);
    run(1, 1, 0, 32'h0, 32'h102);
    chk("fault_set", {31'd0, fetch_fault}, 32'd1);
    run(1, 1, 0, 32'h0, 32'h102);
    chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("fault_cleared", {31'd0, fetch_fault}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(1, 1, 0, 32'h0, 32'h0);
    run(1, 1, 1, 32'h0, 32'h4);
`else
    cycle(1, 1, 1, 32'h102, 0, 32'h0, 32'h100);
    run(1, 1, 1, 32'h100, 32'h104);
    chk("no_fault", {31'd0, fetch_fault}, 32'd0);
    run(1, 1, 1, 32'h104, 32'h108);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
